data_mem_responder: RTL

Responder side of the M-stage data-memory interface of the 5-cycle MIPS pipeline: accepts store/load traffic (memwrite, address, writedata) and returns read data. It also contains a synthesizable store-signature checker that raises sticky done/pass flags, so pass/fail is available on-chip without a bench-side monitor. It sits between the datapath's M stage and the top-level status outputs, and replaces a behavioural data RAM.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/data_mem_responder_sig_checker.sv | 84 ++++++++
 rtl/data_mem_responder.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Purpose : Shared definitions for the M-stage data-memory responder.
//           - The state encoding used by the store-signature checker.
//           - The default success-store signature, shared by the RTL and the
//             bench so they cannot drift apart.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } respState_e;

    localparam logic [31:0] DEF_PASS_ADDR  = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
    localparam logic [31:0] DEF_ALLOW_ADDR = 32'd80;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/data_mem_responder_sig_checker.sv
// ---------------------------------------------------------------------------
// sig_checker
// Purpose : Owns the responder state (CLEAR/RUN/PASS/FAIL), decides the
//           pass/fail verdict from the stream of stores and counts accepted
//           stores.
// Ports   : clk          rising-edge clock
//           rst          synchronous active-low reset
//           memwrite     store strobe
//           addr         store byte address
//           writedata    store data
//           clear_done   the clear sweep writes its last word this cycle
//           state        current state
//           done         verdict reached (sticky until reset)
//           pass         verdict is success
//           store_count  accepted stores, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module sig_checker
    import mips_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        clear_done,
    output respState_e  state,
    output logic        done,
    output logic        pass,
    output logic [15:0] store_count
);

    respState_e stateNext;
    logic       storeAccepted;
    logic       isPassStore;

    // Stores seen while the sweep is running are ignored entirely.
    assign storeAccepted = memwrite && (state != ST_CLEAR);
    assign isPassStore   = (addr == PASS_ADDR) && (writedata == PASS_DATA);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_CLEAR: begin
                if (clear_done) stateNext = ST_RUN;
            end
            ST_RUN: begin
                // Only the success signature passes; anything other than the
                // scratch address (wrong data, misaligned, out of range) fails.
                if (memwrite) begin
                    if (isPassStore) begin
                        stateNext = ST_PASS;
                    end else if (addr != ALLOW_ADDR) begin
                        stateNext = ST_FAIL;
                    end
                end
            end
            default: stateNext = state;   // PASS/FAIL are sticky
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            store_count <= '0;
        end else if (storeAccepted && (store_count != COUNT_MAX)) begin
            store_count <= store_count + 16'd1;
        end
    end

    assign done = (state == ST_PASS) || (state == ST_FAIL);
    assign pass = (state == ST_PASS);

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Purpose : Responder for the M-stage data-memory interface. Holds the data
//           RAM, zeroes it with a sweep after every reset, serves loads
//           combinationally and hosts the store-signature checker that
//           provides on-chip done/pass status.
// Ports   : clk          rising-edge clock
//           rst          synchronous active-low reset (0 = reset)
//           memwrite     store strobe (M stage)
//           addr         byte address (aluoutM)
//           writedata    store data (writedataM)
//           readdata     load data, combinational
//           busy         post-reset clear sweep in progress
//           done         checker verdict reached (sticky)
//           pass         verdict is success, valid when done=1
//           store_count  accepted stores, saturating
// ---------------------------------------------------------------------------
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter int          AW         = 6,
    parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] store_count
);

    logic [31:0] mem [DEPTH];

    respState_e   state;
    logic [AW-1:0] wordIdx;
    logic [AW-1:0] clrIdx;
    logic          inRange;
    logic          aligned;
    logic          inClear;
    logic          clearDone;

    assign wordIdx   = addr[AW+1:2];
    assign inRange   = (addr[31:AW+2] == '0);
    assign aligned   = (addr[1:0] == 2'b00);
    assign inClear   = (state == ST_CLEAR);
    assign clearDone = inClear && (clrIdx == AW'(DEPTH - 1));

    sig_checker #(
        .PASS_ADDR  (PASS_ADDR),
        .PASS_DATA  (PASS_DATA),
        .ALLOW_ADDR (ALLOW_ADDR)
    ) uChecker (
        .clk         (clk),
        .rst         (rst),
        .memwrite    (memwrite),
        .addr        (addr),
        .writedata   (writedata),
        .clear_done  (clearDone),
        .state       (state),
        .done        (done),
        .pass        (pass),
        .store_count (store_count)
    );

    // Sweep index wraps back to 0 after the last word, ready for the next reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clrIdx <= '0;
        end else if (inClear) begin
            clrIdx <= clrIdx + 1'b1;
        end
    end

    // RAM write port: the sweep owns it during CLEAR, stores own it otherwise.
    // Nothing is written on a reset edge so a store racing reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (inClear) begin
                mem[clrIdx] <= '0;
            end else if (memwrite && inRange && aligned) begin
                mem[wordIdx] <= writedata;
            end
        end
    end

    // Reads return pre-edge contents, so a same-cycle store is not forwarded.
    assign readdata = (inRange && !inClear) ? mem[wordIdx] : '0;
    assign busy     = inClear;

endmodule
